// File: rtl/bus_arbiter_decoder_pkg.sv
// Shared definitions for the two-master bus front end: arbiter state encoding,
// master identifiers, address-map page constants and width defaults.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_WDATA_W = 32;
  localparam int unsigned DEF_RDATA_W = 64;

  // Upper address byte selecting each slave's 256-byte window.
  localparam logic [7:0] S0_BASE = 8'h01;
  localparam logic [7:0] S1_BASE = 8'h02;

endpackage

// File: rtl/bus_arbiter_decoder_addr_decoder.sv
// Slave-select decode on the bus address page plus the read-data return mux.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int unsigned RDATA_W = DEF_RDATA_W
) (
  input  logic [7:0]         i_addr_page,
  input  logic               i_granted,
  input  logic [RDATA_W-1:0] i_s0_dout,
  input  logic [RDATA_W-1:0] i_s1_dout,
  output logic               o_s0_sel,
  output logic               o_s1_sel,
  output logic [RDATA_W-1:0] o_m_din
);

  logic w_s0_hit;
  logic w_s1_hit;

  assign w_s0_hit = (i_addr_page == S0_BASE);
  assign w_s1_hit = (i_addr_page == S1_BASE);

  assign o_s0_sel = i_granted & w_s0_hit;
  assign o_s1_sel = i_granted & w_s1_hit;

  // Unmapped pages select nothing, so reads return zero.
  always_comb begin
    o_m_din = '0;
    if (o_s0_sel) begin
      o_m_din = i_s0_dout;
    end else if (o_s1_sel) begin
      o_m_din = i_s1_dout;
    end
  end

endmodule

// File: rtl/bus_arbiter_decoder.sv
// Two-master bus arbiter, bus mux and slave decode; define BUS_ARB_ROUND_ROBIN_EN
// to break simultaneous IDLE contests by last grant instead of fixed M0 priority.
module bus_arbiter_decoder
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned WDATA_W = DEF_WDATA_W,
  parameter int unsigned RDATA_W = DEF_RDATA_W
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               m0_req,
  input  logic               m1_req,
  input  logic               m0_wr,
  input  logic               m1_wr,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [WDATA_W-1:0] m0_dout,
  input  logic [WDATA_W-1:0] m1_dout,
  output logic               m0_grant,
  output logic               m1_grant,
  output logic [RDATA_W-1:0] m_din,
  output logic               S_wr,
  output logic [ADDR_W-1:0]  S_addr,
  output logic [WDATA_W-1:0] s_din,
  output logic               s0_sel,
  output logic               s1_sel,
  input  logic [RDATA_W-1:0] s0_dout,
  input  logic [RDATA_W-1:0] s1_dout
);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic               r_m0_grant;
  logic               r_m1_grant;
  logic               w_granted;
  logic               w_s_wr;
  logic [ADDR_W-1:0]  w_s_addr;
  logic [WDATA_W-1:0] w_s_din;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  master_t r_last_gnt;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) begin
          w_next = (r_last_gnt == M0) ? GNT_M1 : GNT_M0;
        end else if (m0_req) begin
          w_next = GNT_M0;
        end else if (m1_req) begin
          w_next = GNT_M1;
        end
`else
        if (m0_req) begin
          w_next = GNT_M0;
        end else if (m1_req) begin
          w_next = GNT_M1;
        end
`endif
      end
      GNT_M0: begin
        if (!m0_req) begin
          w_next = m1_req ? GNT_M1 : IDLE;
        end
      end
      GNT_M1: begin
        if (!m1_req) begin
          w_next = m0_req ? GNT_M0 : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Grant flops are loaded from the next-state decode so they always equal a
  // decode of r_state, while still coming straight from registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_m0_grant <= 1'b0;
      r_m1_grant <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      r_last_gnt <= M1;
`endif
    end else begin
      r_state    <= w_next;
      r_m0_grant <= (w_next == GNT_M0);
      r_m1_grant <= (w_next == GNT_M1);
`ifdef BUS_ARB_ROUND_ROBIN_EN
      if (w_next == GNT_M0) begin
        r_last_gnt <= M0;
      end else if (w_next == GNT_M1) begin
        r_last_gnt <= M1;
      end
`endif
    end
  end

  always_comb begin
    w_s_wr   = 1'b0;
    w_s_addr = '0;
    w_s_din  = '0;
    case (r_state)
      GNT_M0: begin
        w_s_wr   = m0_wr;
        w_s_addr = m0_addr;
        w_s_din  = m0_dout;
      end
      GNT_M1: begin
        w_s_wr   = m1_wr;
        w_s_addr = m1_addr;
        w_s_din  = m1_dout;
      end
      default: ;
    endcase
  end

  assign w_granted = (r_state != IDLE);

  bus_addr_decoder #(
    .RDATA_W (RDATA_W)
  ) u_addr_decoder (
    .i_addr_page (w_s_addr[ADDR_W-1 -: 8]),
    .i_granted   (w_granted),
    .i_s0_dout   (s0_dout),
    .i_s1_dout   (s1_dout),
    .o_s0_sel    (s0_sel),
    .o_s1_sel    (s1_sel),
    .o_m_din     (m_din)
  );

  assign m0_grant = r_m0_grant;
  assign m1_grant = r_m1_grant;
  assign S_wr     = w_s_wr;
  assign S_addr   = w_s_addr;
  assign s_din    = w_s_din;

endmodule

// File: doc/bus_arbiter_decoder.md
# bus_arbiter_decoder

Two-master shared-bus front end that drives the slave-side bus (Clk, S_wr, S_addr, s_din, sN_sel) seen by the mini processor (slave 0) and a data memory (slave 1). It arbitrates between master 0 (host/loader) and master 1 (DMA/test master), muxes the granted master onto the bus, decodes S_addr into slave selects, and returns the selected slave's read data to the masters. It sits directly upstream of the mini processor and produces its s0_sel, S_wr, S_addr and s_din.

## Interface
- ADDR_W, 16, bus address width
- WDATA_W, 32, write data width
- RDATA_W, 64, slave read data width
- Clk  input  1  rising-edge clock; single clock domain
- Reset_n  input  1  synchronous, active-low reset, sampled on rising Clk
- m0_req, m1_req  input  1  bus request, held high for the whole transfer burst
- m0_wr, m1_wr  input  1  1 = write, 0 = read
- m0_addr, m1_addr  input  ADDR_W  master address
- m0_dout, m1_dout  input  WDATA_W  master write data
- m0_grant, m1_grant  output  1  registered grant, one-hot or zero
- m_din  output  RDATA_W  read data to masters, shared
- S_wr  output  1  bus write strobe
- S_addr  output  ADDR_W  bus address
- s_din  output  WDATA_W  bus write data
- s0_sel  output  1  slave 0 (mini processor) select, address 0x0100–0x01FF
- s1_sel  output  1  slave 1 (memory) select, address 0x0200–0x02FF
- s0_dout, s1_dout  input  RDATA_W  slave read data

## Operation
- Arbiter FSM, states: IDLE (no grant), GNT_M0, GNT_M1; state is registered, grants are a direct decode of state.
- IDLE: m0_req → GNT_M0; else m1_req → GNT_M1; else stay. Both requesting → M0 (fixed priority).
- GNT_M0: stay while m0_req=1 (no pre-emption). On m0_req=0: m1_req=1 → GNT_M1 directly; else IDLE.
- GNT_M1: symmetric; on release with m0_req=1 → GNT_M0 directly.
- Bus mux: combinational from state. GNT_Mx drives S_wr/S_addr/s_din from master x. IDLE drives S_wr=0, S_addr=0, s_din=0.
- Decode: s0_sel = granted & S_addr[15:8]==8'h01; s1_sel = granted & S_addr[15:8]==8'h02; at most one high. Unmapped address: no select, writes dropped, reads return 0.
- m_din = s0_sel ? s0_dout : s1_sel ? s1_dout : 0. Only the granted master may consume m_din.
- Masters must not change m_addr/m_wr/m_dout meaning before seeing their grant; requests with grant low have no bus effect.

## Timing
- Reset (Reset_n=0 at rising edge): state=IDLE; m0_grant=m1_grant=0; S_wr=0, S_addr=0, s_din=0, s0_sel=s1_sel=0, m_din=0. Reset mid-transfer aborts immediately; a write in the same edge is not guaranteed to land.
- Grant latency: req high at edge N → grant high after edge N+1 (1 cycle). Bus fields valid in the same cycle as grant.
- Release: req low at edge N → grant low after edge N+1; handoff to the other master in that same edge (no idle bubble).
- One bus transfer per granted cycle; slave samples on the next rising Clk. Read data is combinational in the grant cycle.
- Simultaneous new requests in IDLE: priority rule (or round-robin, see Configuration) decides; loser waits, its req must stay high.

## Configuration
- BUS_ARB_ROUND_ROBIN_EN defined: add register last_gnt (reset = M1). In IDLE with both requests, grant goes to the master that is not last_gnt; last_gnt updates on every grant. Handoff on release unchanged.
- Not defined: fixed priority M0 > M1, no last_gnt register.

## Structure
- Shared package bus_pkg: state encoding (IDLE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10), address-map constants S0_BASE=8'h01, S1_BASE=8'h02, width defaults.
- One sub-module: bus_addr_decoder (S_addr, granted → s0_sel, s1_sel, plus read-data mux). Arbiter FSM and bus mux stay in the top.

## Test plan
- Reset: hold Reset_n=0 with m0_req=1 for 3 cycles → all outputs 0; release → m0_grant=1 exactly one cycle later.
- Single write: M0 writes 0x00000001 to 0x0120 → S_wr=1, S_addr=0x0120, s_din=1, s0_sel=1, s1_sel=0 in grant cycle.
- Read: M1 reads 0x0205 with s1_dout=64'hDEAD_BEEF_0000_0001 → s1_sel=1, m_din equals that value; address 0x0300 → no sel, m_din=0.
- Contention: m0_req and m1_req rise together → M0 granted (fixed); with BUS_ARB_ROUND_ROBIN_EN, second simultaneous contest after M0 → M1 granted.
- Handoff: M0 holds 4 cycles while M1 waits, M0 drops req → m1_grant high the very next cycle, m0_grant low, no IDLE cycle.
- Reset mid-transfer: Reset_n=0 during GNT_M1 → next edge grants=0, S_wr=0, state IDLE.
